pipeline_ctrl: RTL and testbench

Central stall/flush controller for the five-stage renamed pipeline. It drives `stall`/`flush` of the pc register and the four stage registers (fetch2dec, dec2ex, ex2mem, mem2wb). It resolves load-use, data-memory wait, multi-cycle divide and branch-mispredict events. On a mispredict it walks the active list from tail back to the mispredicted entry, one entry per cycle, so the rename table can roll back.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_rollback_walker.sv | 51 +++++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller and its stage registers.
package pipeline_ctrl_pkg;

  // Active-list index width; the list holds 2^FREE_LIST_WIDTH entries.
  localparam int unsigned FREE_LIST_WIDTH = 3;

  // Controller state encoding; 2'd3 is unused and recovers to StRun.
  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMulti    = 2'd1,
    StRollback = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_rollback_walker.sv
// Walks the active list from tail-1 back to mispredict_index+1, one entry per cycle.
module pipeline_rollback_walker #(
  parameter int unsigned FREE_LIST_WIDTH = pipeline_ctrl_pkg::FREE_LIST_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       active,
  input  logic [FREE_LIST_WIDTH-1:0] al_tail,
  input  logic [FREE_LIST_WIDTH-1:0] mispredict_index,
  output logic                       n_zero,
  output logic                       rollback_valid,
  output logic [FREE_LIST_WIDTH-1:0] rollback_index,
  output logic                       done
);

  localparam logic [FREE_LIST_WIDTH-1:0] IdxOne = FREE_LIST_WIDTH'(1);

  logic [FREE_LIST_WIDTH-1:0] ptr_q, ptr_d;
  logic [FREE_LIST_WIDTH-1:0] last_q, last_d;
  logic [FREE_LIST_WIDTH-1:0] n_entries;

  // Entry count, walk outputs and pointer next-state.
  always_comb begin
    n_entries      = al_tail - mispredict_index - IdxOne;
    n_zero         = (n_entries == '0);
    rollback_valid = active;
    rollback_index = ptr_q;
    done           = active && (ptr_q == last_q);
    ptr_d          = ptr_q;
    last_d         = last_q;
    if (start) begin
      ptr_d  = al_tail - IdxOne;
      last_d = mispredict_index + IdxOne;
    end else if (active) begin
      ptr_d  = ptr_q - IdxOne;
    end
  end

  // Walk pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: load-use, memory wait, multi-cycle divide, mispredict rollback.
module pipeline_ctrl #(
  parameter int unsigned FREE_LIST_WIDTH = pipeline_ctrl_pkg::FREE_LIST_WIDTH,
  parameter int unsigned DIV_CYCLES      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_use_hazard,
  input  logic                       mem_wait,
  input  logic                       div_start,
  input  logic                       mispredict,
  input  logic [FREE_LIST_WIDTH-1:0] mispredict_index,
  input  logic [FREE_LIST_WIDTH-1:0] al_tail,
  output logic                       stall_pc,
  output logic                       stall_f2d,
  output logic                       stall_d2e,
  output logic                       stall_e2m,
  output logic                       stall_m2w,
  output logic                       flush_f2d,
  output logic                       flush_d2e,
  output logic                       flush_e2m,
  output logic                       flush_m2w,
  output logic                       rollback_valid,
  output logic [FREE_LIST_WIDTH-1:0] rollback_index,
  output logic                       div_busy,
  output logic                       div_done,
  output logic [1:0]                 ctrl_state
);

  import pipeline_ctrl_pkg::*;

  localparam int unsigned CntW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(DIV_CYCLES - 1);

  ctrl_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic                       rb_start;
  logic                       rb_n_zero;
  logic                       rb_valid;
  logic [FREE_LIST_WIDTH-1:0] rb_index;
  logic                       rb_done;

  pipeline_rollback_walker #(
    .FREE_LIST_WIDTH(FREE_LIST_WIDTH)
  ) u_walker (
    .clk             (clk),
    .rst             (rst),
    .start           (rb_start),
    .active          (state_q == StRollback),
    .al_tail         (al_tail),
    .mispredict_index(mispredict_index),
    .n_zero          (rb_n_zero),
    .rollback_valid  (rb_valid),
    .rollback_index  (rb_index),
    .done            (rb_done)
  );

  // Priority decode and next-state; every output is held at 0 while rst is high.
  always_comb begin
    stall_pc       = 1'b0;
    stall_f2d      = 1'b0;
    stall_d2e      = 1'b0;
    stall_e2m      = 1'b0;
    stall_m2w      = 1'b0;
    flush_f2d      = 1'b0;
    flush_d2e      = 1'b0;
    flush_e2m      = 1'b0;
    flush_m2w      = 1'b0;
    rollback_valid = 1'b0;
    rollback_index = '0;
    div_busy       = 1'b0;
    div_done       = 1'b0;
    ctrl_state     = 2'd0;
    rb_start       = 1'b0;
    state_d        = state_q;
    cnt_d          = cnt_q;
    if (!rst) begin
      ctrl_state = state_q;
      case (state_q)
        StRun: begin
          // Lower-priority events stay pending: their sources are stalled by mem_wait.
          if (mem_wait) begin
            stall_pc  = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            stall_e2m = 1'b1;
            flush_m2w = 1'b1;
          end else if (mispredict) begin
            flush_f2d = 1'b1;
            flush_d2e = 1'b1;
            if (!rb_n_zero) begin
              rb_start = 1'b1;
              state_d  = StRollback;
            end
          end else if (div_start) begin
            stall_pc  = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            flush_e2m = 1'b1;
            cnt_d     = CntLoad;
            state_d   = StMulti;
          end else if (load_use_hazard) begin
            stall_pc  = 1'b1;
            stall_f2d = 1'b1;
            flush_d2e = 1'b1;
          end
        end
        StMulti: begin
          div_busy = 1'b1;
          if (cnt_q == '0 && !mem_wait) begin
            div_done = 1'b1;
            state_d  = StRun;
          end else begin
            stall_pc  = 1'b1;
            stall_f2d = 1'b1;
            stall_d2e = 1'b1;
            if (mem_wait) begin
              stall_e2m = 1'b1;
              flush_m2w = 1'b1;
            end else begin
              flush_e2m = 1'b1;
            end
            // Counter saturates at 0 so div_done can wait out mem_wait.
            if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          end
        end
        StRollback: begin
          rollback_valid = rb_valid;
          rollback_index = rb_index;
          stall_pc       = 1'b1;
          stall_f2d      = 1'b1;
          flush_d2e      = 1'b1;
          if (mem_wait) begin
            stall_e2m = 1'b1;
            flush_m2w = 1'b1;
          end
          if (rb_done) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State and divide counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver pushes expected outputs, monitor compares on negedge.
module tb_pipeline_ctrl;

  localparam int unsigned W    = 3;
  localparam int unsigned DIV  = 4;
  localparam int          Size = 8;

  logic         clk = 1'b0;
  logic         rst, lu, mw, ds, mp;
  logic [W-1:0] mi, tail;
  logic         stall_pc, stall_f2d, stall_d2e, stall_e2m, stall_m2w;
  logic         flush_f2d, flush_d2e, flush_e2m, flush_m2w;
  logic         rollback_valid, div_busy, div_done;
  logic [W-1:0] rollback_index;
  logic [1:0]   ctrl_state;
  logic [16:0]  act;

  typedef struct {
    logic [16:0] vec;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0 run, 1 divide, 2 rollback.
  int   mode = 0;
  int   div_rem = 0;
  int   rb_q[$];

  pipeline_ctrl #(
    .FREE_LIST_WIDTH(W),
    .DIV_CYCLES     (DIV)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use_hazard (lu),
    .mem_wait        (mw),
    .div_start       (ds),
    .mispredict      (mp),
    .mispredict_index(mi),
    .al_tail         (tail),
    .stall_pc        (stall_pc),
    .stall_f2d       (stall_f2d),
    .stall_d2e       (stall_d2e),
    .stall_e2m       (stall_e2m),
    .stall_m2w       (stall_m2w),
    .flush_f2d       (flush_f2d),
    .flush_d2e       (flush_d2e),
    .flush_e2m       (flush_e2m),
    .flush_m2w       (flush_m2w),
    .rollback_valid  (rollback_valid),
    .rollback_index  (rollback_index),
    .div_busy        (div_busy),
    .div_done        (div_done),
    .ctrl_state      (ctrl_state)
  );

  assign act = {stall_pc, stall_f2d, stall_d2e, stall_e2m, stall_m2w,
                flush_f2d, flush_d2e, flush_e2m, flush_m2w,
                rollback_valid, rollback_index, div_busy, div_done, ctrl_state};

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the outputs, advance the model.
  task automatic cycle(input string name, input logic r, input logic l, input logic m,
                       input logic d, input logic p, input int t, input int i);
    logic s_pc, s_f2d, s_d2e, s_e2m, f_f2d, f_d2e, f_e2m, f_m2w, rv, busy, done;
    logic [16:0] e;
    int ridx, nmode, n;
    rst = r; lu = l; mw = m; ds = d; mp = p;
    tail = t[W-1:0]; mi = i[W-1:0];
    {s_pc, s_f2d, s_d2e, s_e2m, f_f2d, f_d2e, f_e2m, f_m2w, rv, busy, done} = '0;
    ridx = 0; nmode = mode; e = '0;
    if (r) begin
      mode = 0; div_rem = 0; rb_q.delete();
    end else begin
      case (mode)
        0: begin
          if (m) begin
            {s_pc, s_f2d, s_d2e, s_e2m, f_m2w} = '1;
          end else if (p) begin
            {f_f2d, f_d2e} = '1;
            n = ((t - i - 1) % Size + Size) % Size;
            for (int k = 0; k < n; k++) rb_q.push_back(((t - 1 - k) % Size + Size) % Size);
            if (n > 0) nmode = 2;
          end else if (d) begin
            {s_pc, s_f2d, s_d2e, f_e2m} = '1;
            div_rem = DIV - 1;
            nmode = 1;
          end else if (l) begin
            {s_pc, s_f2d, f_d2e} = '1;
          end
        end
        1: begin
          busy = 1'b1;
          if (div_rem == 0 && !m) begin
            done = 1'b1; nmode = 0;
          end else begin
            {s_pc, s_f2d, s_d2e} = '1;
            if (m) {s_e2m, f_m2w} = '1;
            else f_e2m = 1'b1;
            if (div_rem > 0) div_rem--;
          end
        end
        default: begin
          rv = 1'b1;
          ridx = rb_q.pop_front();
          {s_pc, s_f2d, f_d2e} = '1;
          if (m) {s_e2m, f_m2w} = '1;
          if (rb_q.size() == 0) nmode = 0;
        end
      endcase
      e = {s_pc, s_f2d, s_d2e, s_e2m, 1'b0, f_f2d, f_d2e, f_e2m, f_m2w,
           rv, 3'(ridx), busy, done, 2'(mode)};
      mode = nmode;
    end
    exp_q.push_back('{e, name});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    cycle(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Monitor: one comparison per cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (act !== cur.vec) begin
        errors++;
        $display("FAIL %s t=%0t got=%h exp=%h", cur.name, $time, act, cur.vec);
      end
    end
  end

  initial begin
    rst = 1'b1; lu = 1'b0; mw = 1'b0; ds = 1'b0; mp = 1'b0; mi = '0; tail = '0;
    @(posedge clk);
    #1;
    cycle("reset_a", 1, 0, 1, 0, 1, 5, 1);
    cycle("reset_b", 1, 1, 1, 1, 1, 5, 1);
    idle("post_reset");

    cycle("loaduse", 0, 1, 0, 0, 0, 0, 0);
    idle("loaduse_after");

    cycle("div_c0", 0, 0, 0, 1, 0, 0, 0);
    for (int c = 1; c <= 5; c++) idle($sformatf("div_c%0d", c));

    cycle("divmw_c0", 0, 0, 0, 1, 0, 0, 0);
    idle("divmw_c1");
    idle("divmw_c2");
    for (int c = 3; c <= 5; c++) cycle($sformatf("divmw_c%0d", c), 0, 0, 1, 0, 0, 0, 0);
    idle("divmw_c6");
    idle("divmw_c7");

    cycle("rb51_c0", 0, 0, 0, 0, 1, 5, 1);
    for (int c = 1; c <= 4; c++) idle($sformatf("rb51_c%0d", c));

    cycle("rbwrap_c0", 0, 0, 0, 0, 1, 1, 6);
    for (int c = 1; c <= 3; c++) idle($sformatf("rbwrap_c%0d", c));

    cycle("rbnone_c0", 0, 0, 0, 0, 1, 2, 1);
    idle("rbnone_c1");

    cycle("simul_c0", 0, 0, 1, 0, 1, 5, 1);
    cycle("simul_c1", 0, 0, 0, 0, 1, 5, 1);
    for (int c = 2; c <= 5; c++) idle($sformatf("simul_c%0d", c));

    cycle("rbrst_c0", 0, 0, 0, 0, 1, 4, 0);
    idle("rbrst_c1");
    cycle("rbrst_c2", 1, 0, 0, 0, 0, 0, 0);
    cycle("rbrst_c3", 1, 0, 0, 0, 0, 0, 0);
    idle("rbrst_c4");
    idle("rbrst_c5");

    for (int c = 0; c < 600; c++) begin
      cycle("rand",
            $urandom_range(99) < 2,
            $urandom_range(99) < 15,
            $urandom_range(99) < 20,
            $urandom_range(99) < 6,
            $urandom_range(99) < 12,
            int'($urandom_range(7)),
            int'($urandom_range(7)));
    end
    idle("tail_idle");

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
